// File: rtl/phase_drv_pkg.sv
// ============================================================================
// phase_drv_pkg : shared state encoding and defaults for the phase driver
// Rev 1.0
// ============================================================================
`default_nettype none

package phase_drv_pkg;

  localparam int DEAD_TIME_DEF = 32;
  localparam int OVR_LIMIT_DEF = 2;

  typedef enum logic [1:0] {
    DEAD  = 2'd0,
    DRIVE = 2'd1,
    FAULT = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/phase_drv_prot_sync2.sv
// ============================================================================
// sync2 : generic two-flop synchronizer, asynchronous active-low reset
// Rev 1.0
// ============================================================================
`default_nettype none

module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/phase_drv_prot.sv
// ============================================================================
// phase_drv_prot : non-overlapping gate drive with cycle-by-cycle current
//                  chopping and consecutive-period over-current fault latch
// Rev 1.0
// ============================================================================
`default_nettype none

module phase_drv_prot
  import phase_drv_pkg::*;
#(
  parameter int DEAD_TIME = DEAD_TIME_DEF,
  parameter int OVR_LIMIT = OVR_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PWM_sig,
  input  logic PWM_synch,
  input  logic OVR_I_blank_n,
  input  logic OVR_I,
  input  logic clr_fault,
  output logic high_out,
  output logic low_out,
  output logic fault
);

  localparam logic [5:0] DEAD_LAST = 6'(DEAD_TIME - 1);
  localparam logic [4:0] LIMIT     = 5'(OVR_LIMIT);

  state_e     state_q, state_d;
  logic [5:0] dead_cnt_q, dead_cnt_d;
  logic [3:0] cons_cnt_q, cons_cnt_d;
  logic       chop_q, chop_d;
  logic       per_flag_q, per_flag_d;
  logic       fault_q, fault_d;
  logic       eff_q;
  logic       high_q, high_d;
  logic       low_q, low_d;

  logic ovr_s;
  logic ovr_evt;
  logic eff;
  logic eff_chg;
  logic eval;
  logic trip;
  logic clr_ok;

  sync2 #(.WIDTH(1)) u_sync_ovr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (OVR_I),
    .q     (ovr_s)
  );

  assign ovr_evt = ovr_s & OVR_I_blank_n;
  assign eff     = PWM_sig & ~chop_q;
  assign eff_chg = eff ^ eff_q;

  // Over-current bookkeeping; a trip on the same edge as a clear keeps the fault.
  always_comb begin
    chop_d     = chop_q;
    per_flag_d = per_flag_q;
    cons_cnt_d = cons_cnt_q;
    fault_d    = fault_q;
    trip       = 1'b0;
    eval       = per_flag_q | ovr_evt;
    if (PWM_synch) begin
      chop_d     = 1'b0;
      per_flag_d = 1'b0;
      if (eval) begin
        trip = (({1'b0, cons_cnt_q} + 5'd1) >= LIMIT);
        if ({1'b0, cons_cnt_q} < LIMIT) begin
          cons_cnt_d = cons_cnt_q + 4'd1;
        end
      end else begin
        cons_cnt_d = 4'd0;
      end
    end else if (ovr_evt) begin
      chop_d     = 1'b1;
      per_flag_d = 1'b1;
    end
    clr_ok = clr_fault && (state_q == FAULT) && !trip;
    if (trip) begin
      fault_d = 1'b1;
    end else if (clr_ok) begin
      fault_d    = 1'b0;
      cons_cnt_d = 4'd0;
      per_flag_d = 1'b0;
      chop_d     = 1'b0;
    end
  end

  // Outputs are only ever enabled as a complementary pair out of DRIVE.
  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    high_d     = 1'b0;
    low_d      = 1'b0;
    if (fault_d) begin
      state_d    = FAULT;
      dead_cnt_d = 6'd0;
    end else begin
      case (state_q)
        DEAD: begin
          if (eff_chg) begin
            dead_cnt_d = 6'd0;
          end else if (dead_cnt_q == DEAD_LAST) begin
            state_d    = DRIVE;
            dead_cnt_d = 6'd0;
            high_d     = eff_q;
            low_d      = ~eff_q;
          end else begin
            dead_cnt_d = dead_cnt_q + 6'd1;
          end
        end
        DRIVE: begin
          if (eff_chg) begin
            state_d    = DEAD;
            dead_cnt_d = 6'd0;
          end else begin
            high_d = eff_q;
            low_d  = ~eff_q;
          end
        end
        default: begin
          state_d    = DEAD;
          dead_cnt_d = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DEAD;
      dead_cnt_q <= 6'd0;
      cons_cnt_q <= 4'd0;
      chop_q     <= 1'b0;
      per_flag_q <= 1'b0;
      fault_q    <= 1'b0;
      eff_q      <= 1'b0;
      high_q     <= 1'b0;
      low_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      cons_cnt_q <= cons_cnt_d;
      chop_q     <= chop_d;
      per_flag_q <= per_flag_d;
      fault_q    <= fault_d;
      eff_q      <= eff;
      high_q     <= high_d;
      low_q      <= low_d;
    end
  end

  assign high_out = high_q;
  assign low_out  = low_q;
  assign fault    = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_drv_prot.sv
// ============================================================================
// tb_phase_drv_prot : directed-vector bench for phase_drv_prot
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_phase_drv_prot;

  logic clk;
  logic rst_n;
  logic PWM_sig;
  logic PWM_synch;
  logic OVR_I_blank_n;
  logic OVR_I;
  logic clr_fault;
  logic high_out;
  logic low_out;
  logic fault;

  int n_vec;
  int n_err;

  phase_drv_prot #(.DEAD_TIME(32), .OVR_LIMIT(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PWM_sig       (PWM_sig),
    .PWM_synch     (PWM_synch),
    .OVR_I_blank_n (OVR_I_blank_n),
    .OVR_I         (OVR_I),
    .clr_fault     (clr_fault),
    .high_out      (high_out),
    .low_out       (low_out),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s : got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("no_overlap", 32'(high_out & low_out), 0);
  endtask

  // n edges: the first n-1 keep both outputs low, the n-th shows the new level
  task automatic wait_level(input int n, input logic exp_h, input logic exp_l, input string tag);
    for (int i = 0; i < n - 1; i++) begin
      step();
      chk({tag, "_dead_hi"}, 32'(high_out), 0);
      chk({tag, "_dead_lo"}, 32'(low_out), 0);
    end
    step();
    chk({tag, "_hi"}, 32'(high_out), 32'(exp_h));
    chk({tag, "_lo"}, 32'(low_out), 32'(exp_l));
  endtask

  task automatic ovr_pulse();
    OVR_I = 1'b1;
    step();
    OVR_I = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic synch_pulse();
    PWM_synch = 1'b1;
    step();
    PWM_synch = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    PWM_sig = 1'b0;
    PWM_synch = 1'b0;
    OVR_I_blank_n = 1'b0;
    OVR_I = 1'b0;
    clr_fault = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", 32'(high_out), 0);
    chk("rst_lo", 32'(low_out), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cnt", 32'(dut.cons_cnt_q), 0);
    rst_n = 1'b1;
    wait_level(32, 1'b0, 1'b1, "por_low");

    // toggle to high, then back to low at cycle 10 of dead time
    PWM_sig = 1'b1;
    step();
    chk("tog_lo_off", 32'(low_out), 0);
    chk("tog_hi_off", 32'(high_out), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("tog_dead", 32'(high_out | low_out), 0);
    end
    PWM_sig = 1'b0;
    wait_level(33, 1'b0, 1'b1, "retog_low");
    PWM_sig = 1'b1;
    wait_level(33, 1'b1, 1'b0, "drive_high");

    // over-current during blanking must be ignored
    OVR_I = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("blank_hi", 32'(high_out), 1);
      chk("blank_chop", 32'(dut.chop_q), 0);
    end
    OVR_I = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blank_flush_hi", 32'(high_out), 1);
    end
    synch_pulse();
    chk("blank_cnt", 32'(dut.cons_cnt_q), 0);
    chk("blank_hi_end", 32'(high_out), 1);

    // valid event chops the high side: sync, chop, dead entry
    OVR_I_blank_n = 1'b1;
    OVR_I = 1'b1;
    step();
    chk("chopA_hi", 32'(high_out), 1);
    OVR_I = 1'b0;
    step();
    chk("chopB_hi", 32'(high_out), 1);
    step();
    chk("chopC_hi", 32'(high_out), 1);
    chk("chopC_chop", 32'(dut.chop_q), 1);
    step();
    chk("chopD_hi", 32'(high_out), 0);
    chk("chopD_lo", 32'(low_out), 0);
    repeat (5) step();
    synch_pulse();
    chk("chop_cnt", 32'(dut.cons_cnt_q), 1);
    chk("chop_cleared", 32'(dut.chop_q), 0);
    wait_level(33, 1'b1, 1'b0, "chop_resume");

    // event / clean / event periods
    synch_pulse();
    chk("seq_clean0", 32'(dut.cons_cnt_q), 0);
    ovr_pulse();
    synch_pulse();
    chk("seq_p1_cnt", 32'(dut.cons_cnt_q), 1);
    chk("seq_p1_fault", 32'(fault), 0);
    synch_pulse();
    chk("seq_p2_cnt", 32'(dut.cons_cnt_q), 0);
    ovr_pulse();
    synch_pulse();
    chk("seq_p3_cnt", 32'(dut.cons_cnt_q), 1);
    chk("seq_p3_fault", 32'(fault), 0);

    // clear outside FAULT is ignored
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    chk("clr_ign_cnt", 32'(dut.cons_cnt_q), 1);
    chk("clr_ign_fault", 32'(fault), 0);

    // second consecutive period trips the fault on the synch edge
    ovr_pulse();
    synch_pulse();
    chk("trip_fault", 32'(fault), 1);
    chk("trip_hi", 32'(high_out), 0);
    chk("trip_lo", 32'(low_out), 0);
    chk("trip_cnt", 32'(dut.cons_cnt_q), 2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault_hold", 32'(fault), 1);
      chk("fault_outs", 32'(high_out | low_out), 0);
    end

    // trip coinciding with clear keeps the fault
    ovr_pulse();
    PWM_synch = 1'b1;
    clr_fault = 1'b1;
    step();
    PWM_synch = 1'b0;
    clr_fault = 1'b0;
    chk("trip_wins", 32'(fault), 1);
    PWM_sig = 1'b0;
    step();
    step();
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    chk("clr_fault", 32'(fault), 0);
    chk("clr_cnt", 32'(dut.cons_cnt_q), 0);
    chk("clr_chop", 32'(dut.chop_q), 0);
    chk("clr_outs", 32'(high_out | low_out), 0);
    wait_level(32, 1'b0, 1'b1, "clr_low");

    // asynchronous reset mid-DRIVE
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_drive_lo", 32'(low_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // asynchronous reset mid-FAULT
    ovr_pulse();
    synch_pulse();
    ovr_pulse();
    synch_pulse();
    chk("fault2", 32'(fault), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fault", 32'(fault), 0);
    chk("arst_cnt", 32'(dut.cons_cnt_q), 0);
    chk("arst_outs", 32'(high_out | low_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_level(32, 1'b0, 1'b1, "post_arst");
    chk("post_arst_fault", 32'(fault), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/phase_drv_prot.md
PHASE_DRV_PROT -- requirements
Module: phase_drv_prot

Interface
REQ-001 The block SHALL have parameter DEAD_TIME, default 32, legal range 2..63: non-overlap delay in clk cycles.
REQ-002 The block SHALL have parameter OVR_LIMIT, default 2, legal range 1..15: consecutive over-current PWM periods that trip a fault.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 PWM_sig  input  1  raw PWM from the 11-bit PWM generator; 1 = high-side phase.
REQ-006 PWM_synch  input  1  single-cycle pulse marking the end of each PWM period.
REQ-007 OVR_I_blank_n  input  1  1 = current-sense window is valid; 0 = switching-noise blanking.
REQ-008 OVR_I  input  1  asynchronous over-current comparator output, active-high.
REQ-009 clr_fault  input  1  synchronous single-cycle fault clear request.
REQ-010 high_out  output  1  registered high-side gate drive.
REQ-011 low_out  output  1  registered low-side gate drive.
REQ-012 fault  output  1  registered latched over-current fault.

Function
REQ-013 OVR_I SHALL pass through a 2-flop synchronizer (ovr_s) before any use.
REQ-014 An event SHALL be one cycle with ovr_s=1 and OVR_I_blank_n=1; events during blanking are ignored.
REQ-015 Chop flag: an event SHALL set chop on the next edge; a cycle with PWM_synch=1 SHALL clear chop on the next edge; a simultaneous event and PWM_synch SHALL clear chop.
REQ-016 Effective drive eff = PWM_sig & ~chop; eff_q is eff registered one cycle.
REQ-017 Period flag: an event SHALL set per_flag; on PWM_synch, (per_flag | event) SHALL be evaluated and per_flag cleared.
REQ-018 On PWM_synch with evaluation true, the 4-bit consecutive counter SHALL increment; with evaluation false, it SHALL clear to 0.
REQ-019 When the increment reaches OVR_LIMIT, fault SHALL assert on that same edge; the counter saturates and does not wrap.
REQ-020 FSM states SHALL be DEAD, DRIVE, FAULT.
REQ-021 DEAD: high_out=low_out=0; the 6-bit dead counter counts up each cycle; eff!=eff_q SHALL restart it at 0; at DEAD_TIME-1 with no change, go to DRIVE.
REQ-022 DRIVE: high_out=eff_q, low_out=~eff_q; eff!=eff_q SHALL go to DEAD with both outputs low on that same edge.
REQ-023 Any state with fault set SHALL go to FAULT; both outputs 0; dead counter held at 0.
REQ-024 FAULT: clr_fault=1 SHALL clear fault, the consecutive counter, per_flag and chop, and go to DEAD.
REQ-025 clr_fault outside FAULT SHALL be ignored; if a trip and clr_fault coincide, the trip SHALL win.
REQ-026 high_out and low_out SHALL never be 1 simultaneously under any input sequence.
REQ-027 Latency: a new output level SHALL assert exactly DEAD_TIME edges after the edge that deasserted both outputs, provided eff is stable.

Reset
REQ-028 Reset SHALL force state=DEAD, dead counter=0, high_out=0, low_out=0, fault=0, chop=0, per_flag=0, consecutive counter=0, synchronizer flops=0, eff_q=0.
REQ-029 After reset release with PWM_sig=0, low_out SHALL assert DEAD_TIME cycles later.
REQ-030 Reset mid-DRIVE or mid-FAULT SHALL take effect immediately and asynchronously; fault is not retained.

Structure
REQ-031 Package phase_drv_pkg SHALL hold the state enum (DEAD, DRIVE, FAULT) and the default constants DEAD_TIME_DEF=32 and OVR_LIMIT_DEF=2.
REQ-032 The block SHALL contain one sub-module, sync2: a generic 2-flop synchronizer with asynchronous active-low reset.
REQ-033 All other logic SHALL be flat within phase_drv_prot.

Verification
REQ-034 Reset, PWM_sig=0, DEAD_TIME=32 -> low_out=1 at cycle 32 after release; high_out=0 throughout.
REQ-035 PWM_sig 0->1 in DRIVE -> low_out=0 next edge, high_out=1 32 edges later; a second toggle at cycle 10 of dead time -> dead counter restarts, no overlap.
REQ-036 OVR_I=1 for 5 cycles with OVR_I_blank_n=0 -> no chop, counter stays 0, outputs unaffected.
REQ-037 Event mid-period with OVR_I_blank_n=1 while PWM_sig=1 -> high_out=0 within 4 cycles (sync + chop + dead entry); drive resumes through dead time after PWM_synch; counter=1.
REQ-038 Events in 2 consecutive periods (OVR_LIMIT=2) -> fault=1 on the second PWM_synch edge, both outputs 0; clr_fault pulse -> fault=0, low_out=1 DEAD_TIME cycles later.
REQ-039 Event in period 1, clean period 2, event in period 3 -> counter 1, 0, 1; no fault.
